// File: rtl/brick_pkg.sv
// Shared brick-field geometry, redraw request payload and address helpers.
package brick_pkg;

    localparam int unsigned BX_LOG2     = 5;
    localparam int unsigned BY_LOG2     = 4;
    localparam int unsigned COLS        = 20;
    localparam int unsigned ROWS        = 8;
    localparam int unsigned HEALTH_INIT = 3;

    localparam int unsigned NBRICKS  = COLS * ROWS;
    localparam int unsigned IDX_W    = $clog2(NBRICKS);
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned HEALTH_W = 2;
    localparam int unsigned LEFT_W   = 8;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [HEALTH_W-1:0] health;
    } redraw_req_t;

    function automatic logic in_field(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ((x >> BX_LOG2) < COORD_W'(COLS)) && ((y >> BY_LOG2) < COORD_W'(ROWS));
    endfunction

    // Only meaningful when in_field() holds; callers gate the result.
    function automatic logic [IDX_W-1:0] brick_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
        col = x >> BX_LOG2;
        row = y >> BY_LOG2;
        return IDX_W'(row * COORD_W'(COLS) + col);
    endfunction

    function automatic logic [COORD_W-1:0] origin_x(input logic [COORD_W-1:0] x);
        return (x >> BX_LOG2) << BX_LOG2;
    endfunction

    function automatic logic [COORD_W-1:0] origin_y(input logic [COORD_W-1:0] y);
        return (y >> BY_LOG2) << BY_LOG2;
    endfunction

endpackage

// File: rtl/redraw_fifo.sv
// Show-ahead redraw queue: two pushes (push0 ordered first) and one pop per cycle,
// excess pushes are dropped and latch a sticky overflow flag.
module redraw_fifo
    import brick_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_push0,
    input  redraw_req_t i_data0,
    input  logic        i_push1,
    input  redraw_req_t i_data1,
    input  logic        i_pop,
    output logic        o_valid,
    output redraw_req_t o_data,
    output logic        o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    redraw_req_t r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [CW-1:0] w_nreq;
    logic [CW-1:0] w_nacc;
    logic          w_drop;
    redraw_req_t   w_first;

    // Free space counts the slot released by a same-cycle pop.
    always_comb begin
        w_pop   = i_pop && (r_count != '0);
        w_free  = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
        w_nreq  = CW'(i_push0) + CW'(i_push1);
        w_drop  = w_nreq > w_free;
        w_nacc  = w_drop ? w_free : w_nreq;
        w_first = i_push0 ? i_data0 : i_data1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_nacc != '0) begin
                r_mem[r_wr] <= w_first;
            end
            if (w_nacc == CW'(2)) begin
                r_mem[r_wr + AW'(1)] <= i_data1;
            end
            r_wr    <= r_wr + AW'(w_nacc);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + w_nacc - CW'(w_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_data     = r_mem[r_rd];
    assign o_overflow = r_ovf;

endmodule

// File: rtl/brick_memory.sv
// Brick-field store: answers collision probes, applies hit damage, counts survivors
// and queues redraw requests for the drawing stage.
module brick_memory
    import brick_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reload,
    input  logic [9:0]  memx,
    input  logic [9:0]  memy,
    output logic [1:0]  health,
    output logic [9:0]  brickx,
    output logic [9:0]  bricky,
    input  logic        hit_1,
    input  logic [9:0]  hit_x1,
    input  logic [9:0]  hit_y1,
    input  logic        hit_2,
    input  logic [9:0]  hit_x2,
    input  logic [9:0]  hit_y2,
    output logic        draw_valid,
    input  logic        draw_ready,
    output logic [9:0]  draw_x,
    output logic [9:0]  draw_y,
    output logic [1:0]  draw_health,
    output logic [7:0]  bricks_left,
    output logic        cleared,
    output logic        overflow
);

    logic [HEALTH_W-1:0] r_field [NBRICKS];
    logic [HEALTH_W-1:0] r_health;
    logic [COORD_W-1:0]  r_brickx;
    logic [COORD_W-1:0]  r_bricky;
    logic [LEFT_W-1:0]   r_left;

    logic                w_pin;
    logic [IDX_W-1:0]    w_pidx;
    logic                w_in1;
    logic                w_in2;
    logic [IDX_W-1:0]    w_idx1;
    logic [IDX_W-1:0]    w_idx2;
    logic [HEALTH_W-1:0] w_h1;
    logic [HEALTH_W-1:0] w_h2;
    logic                w_eff1;
    logic                w_eff2;
    logic [LEFT_W-1:0]   w_kill;
    redraw_req_t         w_req1;
    redraw_req_t         w_req2;
    redraw_req_t         w_head;
    logic                w_valid;
    logic                w_ovf;

    // Hit qualification; a second hit on the brick already hit by hit_1 is folded into it.
    always_comb begin
        w_pin  = in_field(memx, memy);
        w_pidx = w_pin ? brick_idx(memx, memy) : '0;
        w_in1  = in_field(hit_x1, hit_y1);
        w_in2  = in_field(hit_x2, hit_y2);
        w_idx1 = w_in1 ? brick_idx(hit_x1, hit_y1) : '0;
        w_idx2 = w_in2 ? brick_idx(hit_x2, hit_y2) : '0;
        w_h1   = w_in1 ? r_field[w_idx1] : '0;
        w_h2   = w_in2 ? r_field[w_idx2] : '0;
        w_eff1 = hit_1 && (w_h1 != '0) && !reload;
        w_eff2 = hit_2 && (w_h2 != '0) && !reload && !(w_eff1 && (w_idx1 == w_idx2));
        w_kill = LEFT_W'(w_eff1 && (w_h1 == HEALTH_W'(1)))
               + LEFT_W'(w_eff2 && (w_h2 == HEALTH_W'(1)));
        w_req1 = '{x: origin_x(hit_x1), y: origin_y(hit_y1), health: w_h1 - HEALTH_W'(1)};
        w_req2 = '{x: origin_x(hit_x2), y: origin_y(hit_y2), health: w_h2 - HEALTH_W'(1)};
    end

    // Field state and bricks-left counter.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < int'(NBRICKS); i++) begin
                r_field[i] <= HEALTH_W'(HEALTH_INIT);
            end
            r_left <= LEFT_W'(NBRICKS);
        end else if (reload) begin
            for (int i = 0; i < int'(NBRICKS); i++) begin
                r_field[i] <= HEALTH_W'(HEALTH_INIT);
            end
            r_left <= LEFT_W'(NBRICKS);
        end else begin
            if (w_eff1) begin
                r_field[w_idx1] <= w_req1.health;
            end
            if (w_eff2) begin
                r_field[w_idx2] <= w_req2.health;
            end
            r_left <= r_left - w_kill;
        end
    end

    // Probe port samples the array before this edge's hit updates land.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_health <= '0;
            r_brickx <= '0;
            r_bricky <= '0;
        end else begin
            r_health <= (w_pin && !reload) ? r_field[w_pidx] : '0;
            r_brickx <= origin_x(memx);
            r_bricky <= origin_y(memy);
        end
    end

    redraw_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (resetn),
        .i_flush    (reload),
        .i_push0    (w_eff1),
        .i_data0    (w_req1),
        .i_push1    (w_eff2),
        .i_data1    (w_req2),
        .i_pop      (draw_ready),
        .o_valid    (w_valid),
        .o_data     (w_head),
        .o_overflow (w_ovf)
    );

    assign health      = r_health;
    assign brickx      = r_brickx;
    assign bricky      = r_bricky;
    assign draw_valid  = w_valid;
    assign draw_x      = w_head.x;
    assign draw_y      = w_head.y;
    assign draw_health = w_head.health;
    assign bricks_left = r_left;
    assign cleared     = (r_left == '0);
    assign overflow    = w_ovf;

endmodule

// File: tb/tb_brick_memory.sv
// Scoreboard bench for brick_memory: a behavioural field/queue model predicts every
// probe result and redraw request.
module tb_brick_memory;

    logic       clk = 1'b0;
    logic       resetn;
    logic       reload;
    logic [9:0] memx, memy;
    logic [1:0] health;
    logic [9:0] brickx, bricky;
    logic       hit_1, hit_2;
    logic [9:0] hit_x1, hit_y1, hit_x2, hit_y2;
    logic       draw_valid, draw_ready;
    logic [9:0] draw_x, draw_y;
    logic [1:0] draw_health;
    logic [7:0] bricks_left;
    logic       cleared, overflow;

    always #5 clk = ~clk;

    brick_memory #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .reload(reload),
        .memx(memx), .memy(memy), .health(health), .brickx(brickx), .bricky(bricky),
        .hit_1(hit_1), .hit_x1(hit_x1), .hit_y1(hit_y1),
        .hit_2(hit_2), .hit_x2(hit_x2), .hit_y2(hit_y2),
        .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_health(draw_health),
        .bricks_left(bricks_left), .cleared(cleared), .overflow(overflow)
    );

    typedef struct { int x; int y; int h; } req_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_field [160];
    int   m_left;
    int   m_ovf;
    req_t exp_q [$];
    req_t probe_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_in(input int x, input int y);
        return ((x / 32) < 20 && (y / 16) < 8) ? 1 : 0;
    endfunction

    function automatic int m_idx(input int x, input int y);
        return (y / 16) * 20 + (x / 32);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 160; i++) m_field[i] = 3;
        m_left = 160;
        m_ovf  = 0;
        exp_q.delete();
        probe_q.delete();
    endtask

    task automatic push_req(input int x, input int y, input int h);
        req_t r;
        r.x = (x / 32) * 32; r.y = (y / 16) * 16; r.h = h;
        if (exp_q.size() < 4) exp_q.push_back(r);
        else m_ovf = 1;
    endtask

    task automatic idle_inputs();
        reload = 0; hit_1 = 0; hit_2 = 0;
        hit_x1 = 0; hit_y1 = 0; hit_x2 = 0; hit_y2 = 0;
    endtask

    // One clock: predict, advance, compare.
    task automatic step();
        req_t r, p;
        int   i1, i2;
        check("draw_valid", int'(draw_valid), (exp_q.size() != 0) ? 1 : 0);
        if (exp_q.size() != 0 && draw_ready) begin
            r = exp_q.pop_front();
            check("draw_x", int'(draw_x), r.x);
            check("draw_y", int'(draw_y), r.y);
            check("draw_health", int'(draw_health), r.h);
        end
        p.x = (int'(memx) / 32) * 32;
        p.y = (int'(memy) / 16) * 16;
        p.h = (!reload && m_in(int'(memx), int'(memy)) != 0) ? m_field[m_idx(int'(memx), int'(memy))] : 0;
        probe_q.push_back(p);
        if (reload) begin
            for (int i = 0; i < 160; i++) m_field[i] = 3;
            m_left = 160;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            i1 = -1; i2 = -1;
            if (hit_1 && m_in(int'(hit_x1), int'(hit_y1)) != 0 && m_field[m_idx(int'(hit_x1), int'(hit_y1))] != 0)
                i1 = m_idx(int'(hit_x1), int'(hit_y1));
            if (hit_2 && m_in(int'(hit_x2), int'(hit_y2)) != 0 && m_field[m_idx(int'(hit_x2), int'(hit_y2))] != 0
                && m_idx(int'(hit_x2), int'(hit_y2)) != i1)
                i2 = m_idx(int'(hit_x2), int'(hit_y2));
            if (i1 >= 0) begin
                m_field[i1]--;
                if (m_field[i1] == 0) m_left--;
                push_req(int'(hit_x1), int'(hit_y1), m_field[i1]);
            end
            if (i2 >= 0) begin
                m_field[i2]--;
                if (m_field[i2] == 0) m_left--;
                push_req(int'(hit_x2), int'(hit_y2), m_field[i2]);
            end
        end
        @(posedge clk); #1;
        p = probe_q.pop_front();
        check("health", int'(health), p.h);
        check("brickx", int'(brickx), p.x);
        check("bricky", int'(bricky), p.y);
        check("bricks_left", int'(bricks_left), m_left);
        check("cleared", int'(cleared), (m_left == 0) ? 1 : 0);
        check("overflow", int'(overflow), m_ovf);
    endtask

    initial begin
        resetn = 1; draw_ready = 0; memx = 0; memy = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_health", int'(health), 0);
        check("rst_brickx", int'(brickx), 0);
        check("rst_bricky", int'(bricky), 0);
        check("rst_draw_valid", int'(draw_valid), 0);
        check("rst_bricks_left", int'(bricks_left), 160);
        check("rst_cleared", int'(cleared), 0);
        check("rst_overflow", int'(overflow), 0);
        resetn = 0;

        // Basic and out-of-field probes.
        memx = 40; memy = 20;  step();
        memx = 40; memy = 200; step();
        memx = 640; memy = 0;  step();
        memx = 639; memy = 127; step();

        // Repeated hits on one brick, probing it on the same edge.
        draw_ready = 1;
        memx = 32; memy = 16;
        for (int k = 0; k < 4; k++) begin
            hit_1 = 1; hit_x1 = 32; hit_y1 = 16;
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Both faces of the same brick in one cycle.
        memx = 64; memy = 0;
        hit_1 = 1; hit_x1 = 64; hit_y1 = 0;
        hit_2 = 1; hit_x2 = 64; hit_y2 = 0;
        step();
        idle_inputs();
        repeat (3) step();

        // Two different bricks per cycle with the drawer stalled.
        draw_ready = 0;
        for (int k = 0; k < 4; k++) begin
            memx = 608; memy = 112;
            hit_1 = 1; hit_x1 = 0;   hit_y1 = 0;
            hit_2 = 1; hit_x2 = 608; hit_y2 = 112;
            step();
        end
        idle_inputs();
        memx = 0; memy = 0; step();
        draw_ready = 1;
        repeat (6) step();

        // Out-of-field hit is ignored.
        hit_1 = 1; hit_x1 = 700; hit_y1 = 0;
        hit_2 = 1; hit_x2 = 0;   hit_y2 = 300;
        step();
        idle_inputs();

        // Wear down the whole field.
        for (int i = 0; i < 160; i++) begin
            for (int k = 0; k < 3; k++) begin
                hit_1 = 1; hit_x1 = 10'((i % 20) * 32); hit_y1 = 10'((i / 20) * 16);
                hit_2 = 1; hit_x2 = 10'($urandom_range(0, 1023)); hit_y2 = 10'($urandom_range(0, 255));
                memx = 10'($urandom_range(0, 1023)); memy = 10'($urandom_range(0, 1023));
                draw_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        idle_inputs();
        draw_ready = 1;
        repeat (6) step();
        check("cleared_final", int'(cleared), 1);

        // Reload with stalled queue and a hit that must be discarded.
        draw_ready = 0;
        hit_1 = 1; hit_x1 = 96; hit_y1 = 32;
        step();
        idle_inputs();
        reload = 1; hit_1 = 1; hit_x1 = 0; hit_y1 = 0;
        memx = 0; memy = 0;
        step();
        idle_inputs();
        check("reload_left", int'(bricks_left), 160);
        check("reload_valid", int'(draw_valid), 0);
        step();

        // Asynchronous reset with queued entries and overflow set.
        for (int k = 0; k < 3; k++) begin
            hit_1 = 1; hit_x1 = 128; hit_y1 = 48;
            hit_2 = 1; hit_x2 = 160; hit_y2 = 64;
            step();
        end
        idle_inputs();
        #2;
        resetn = 1;
        #1;
        check("arst_valid", int'(draw_valid), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_left", int'(bricks_left), 160);
        check("arst_health", int'(health), 0);
        @(posedge clk); #1;
        resetn = 0;
        model_reset();
        memx = 128; memy = 48;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
